alu_issue_sched: RTL and testbench
==================================

ALU_ISSUE_SCHED -- requirements
Module: alu_issue_sched

Interface
REQ-001 Parameter: RS_DEPTH, default 8, number of ALU reservation-station entries (power of two, 2..16).
REQ-002 Parameter: ROB_DEPTH, default 16, ROB entries; ROB tags are 5 bits, valid range 0..ROB_DEPTH-1.
REQ-003 Ports (clock and reset first):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- disp_valid  in  1  dispatch offers one ALU op this cycle
- disp_opcode / disp_func3 / disp_func7  in  7/3/7  decoded instruction fields
- disp_imm  in  32  immediate
- disp_ps1 / disp_ps2 / disp_pd  in  7/7/7  physical source and destination registers
- disp_rob_index  in  5  ROB tag of the op
- disp_ps1_rdy / disp_ps2_rdy  in  1/1  source operand already available at dispatch
- rs_full  out  1  no free entry; dispatch must not assert disp_valid
- cdb_valid / cdb_tag  in  1/7  writeback broadcast of a physical register
- rob_head  in  5  oldest in-flight ROB tag
- rob_tail  in  5  next ROB tag to allocate
- mispredict / mispredict_tag  in  1/5  branch-resolution flush request
- fu_alu_ready  in  1  ALU accepts an op this cycle
- issued  out  1  one op issued to the ALU this cycle
- iss_opcode / iss_func3 / iss_func7 / iss_imm / iss_ps1 / iss_ps2 / iss_pd / iss_rob_index  out  widths as disp_*  issued op fields; iss_ps1/iss_ps2 drive PRF read addresses

Function
REQ-004 Each entry SHALL hold: valid, all disp_* fields, rdy1, rdy2.
REQ-005 Dispatch: disp_valid && !rs_full && !mispredict SHALL write the lowest-index free entry at the clock edge, with valid=1.
REQ-006 rs_full SHALL be combinational: 1 when all RS_DEPTH entries are valid, regardless of an issue in the same cycle.
REQ-007 Wakeup: cdb_valid SHALL set rdy1 of every valid entry whose ps1 == cdb_tag, and likewise rdy2/ps2; tag 0 (x0) is always ready.
REQ-008 A dispatching op SHALL also capture a same-cycle CDB match into its rdy bits.
REQ-009 An entry is eligible when valid && rdy1 && rdy2; ops with opcode 7'b0010011 or 7'b0110111 SHALL ignore rdy2.
REQ-010 Select: among eligible entries, the one with the smallest age (rob_index - rob_head) mod ROB_DEPTH SHALL win; ties cannot occur.
REQ-011 Issue: issued SHALL be combinational, 1 when fu_alu_ready && an eligible entry exists && !mispredict; iss_* SHALL show the winner's fields in the same cycle.
REQ-012 On the edge where issued=1, the winning entry SHALL be freed; issue latency from last operand wakeup is 1 cycle (wakeup edge, issue next cycle).
REQ-013 When issued=0, iss_* SHALL be all zeros.
REQ-014 Flush: on mispredict, every valid entry whose rob_index lies strictly after mispredict_tag and strictly before rob_tail in circular order (wrap ROB_DEPTH-1 -> 0) SHALL be freed at that edge; older entries and the branch itself SHALL be retained.
REQ-015 mispredict_tag == ROB_DEPTH-1 SHALL start the flush window at tag 0; an empty window (mispredict_tag+1 == rob_tail) frees nothing.
REQ-016 In a mispredict cycle, dispatch and issue SHALL both be suppressed; wakeup SHALL still apply to surviving entries.
REQ-017 Dispatch, wakeup and issue in the same cycle SHALL all take effect; an entry freed by issue is not reusable until the next cycle.

Reset
REQ-018 Asynchronous reset SHALL clear all valid, rdy1 and rdy2 bits and all entry fields; after reset rs_full=0, issued=0, iss_*=0.
REQ-019 Reset asserted mid-operation SHALL discard all held ops with no issue.

Configuration
REQ-020 Macro ALU_RS_BYPASS_EN: when defined, an entry woken by cdb_valid/cdb_tag SHALL be eligible in that same cycle (combinational wakeup-to-select, 0-cycle latency), including an op being dispatched? No -- dispatching ops are never eligible; when undefined, eligibility uses registered rdy bits only (REQ-012).

Verification
REQ-021 Dispatch addi (ps1_rdy=1, rob 3), fu_alu_ready=1 -> issued=1 next cycle with iss_rob_index=3, entry freed.
REQ-022 Fill 8 entries with unready ps1=P20 -> rs_full=1; cdb_tag=20 -> entries issue one per cycle, oldest rob first, rs_full drops after first issue.
REQ-023 rob_head=14; eligible entries rob 15, 1, 14 -> issue order 14, 15, 1.
REQ-024 Entries rob 2..7, rob_tail=8, mispredict_tag=4 -> rob 5,6,7 freed, 2,3,4 kept, issued=0 that cycle; mispredict_tag=15, rob_tail=2 -> rob 0,1 freed.
REQ-025 cdb_tag=9 same cycle as dispatch with ps2=9, ps2_rdy=0 -> rdy2 set; with ALU_RS_BYPASS_EN, existing entry woken by tag 9 issues that cycle, without it one cycle later.
REQ-026 Reset asserted with 5 valid entries -> rs_full=0, issued=0 immediately, no issue after release.

Source files
------------

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: ALU reservation station with CDB wakeup, oldest-first select and mispredict flush.
// Define ALU_RS_BYPASS_EN to let a same-cycle CDB wakeup make an entry eligible (0-cycle wakeup-to-issue).
module alu_issue_sched #(
    parameter int RS_DEPTH  = 8,
    parameter int ROB_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_valid,
    input  logic [6:0]  disp_opcode,
    input  logic [2:0]  disp_func3,
    input  logic [6:0]  disp_func7,
    input  logic [31:0] disp_imm,
    input  logic [6:0]  disp_ps1,
    input  logic [6:0]  disp_ps2,
    input  logic [6:0]  disp_pd,
    input  logic [4:0]  disp_rob_index,
    input  logic        disp_ps1_rdy,
    input  logic        disp_ps2_rdy,
    output logic        rs_full,
    input  logic        cdb_valid,
    input  logic [6:0]  cdb_tag,
    input  logic [4:0]  rob_head,
    input  logic [4:0]  rob_tail,
    input  logic        mispredict,
    input  logic [4:0]  mispredict_tag,
    input  logic        fu_alu_ready,
    output logic        issued,
    output logic [6:0]  iss_opcode,
    output logic [2:0]  iss_func3,
    output logic [6:0]  iss_func7,
    output logic [31:0] iss_imm,
    output logic [6:0]  iss_ps1,
    output logic [6:0]  iss_ps2,
    output logic [6:0]  iss_pd,
    output logic [4:0]  iss_rob_index
);
    localparam int IW = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] r_valid, r_rdy1, r_rdy2;
    logic [6:0]          r_opcode [RS_DEPTH];
    logic [2:0]          r_func3  [RS_DEPTH];
    logic [6:0]          r_func7  [RS_DEPTH];
    logic [31:0]         r_imm    [RS_DEPTH];
    logic [6:0]          r_ps1    [RS_DEPTH];
    logic [6:0]          r_ps2    [RS_DEPTH];
    logic [6:0]          r_pd     [RS_DEPTH];
    logic [4:0]          r_rob    [RS_DEPTH];

    logic [RS_DEPTH-1:0] w_wake1, w_wake2, w_rdy1_eff, w_rdy2_eff, w_elig, w_flush;
    logic [IW-1:0]       w_free_idx, w_win;
    logic                w_found, w_disp;
    logic [4:0]          w_best_age, w_start, w_win_len;

    // (a - b) mod ROB_DEPTH for tags already inside 0..ROB_DEPTH-1
    function automatic logic [4:0] f_dist(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + 6'(ROB_DEPTH) - {1'b0, b};
        return (s >= 6'(ROB_DEPTH)) ? 5'(s - 6'(ROB_DEPTH)) : s[4:0];
    endfunction

    always_comb begin
        w_start   = (mispredict_tag == 5'(ROB_DEPTH - 1)) ? 5'd0 : mispredict_tag + 5'd1;
        w_win_len = f_dist(rob_tail, w_start);
        w_wake1   = '0;
        w_wake2   = '0;
        w_flush   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_wake1[i] = cdb_valid && (r_ps1[i] == cdb_tag);
            w_wake2[i] = cdb_valid && (r_ps2[i] == cdb_tag);
            w_flush[i] = r_valid[i] && (f_dist(r_rob[i], w_start) < w_win_len);
        end
    end

`ifdef ALU_RS_BYPASS_EN
    assign w_rdy1_eff = r_rdy1 | w_wake1;
    assign w_rdy2_eff = r_rdy2 | w_wake2;
`else
    assign w_rdy1_eff = r_rdy1;
    assign w_rdy2_eff = r_rdy2;
`endif

    always_comb begin
        w_elig     = '0;
        w_found    = 1'b0;
        w_win      = '0;
        w_best_age = '1;
        w_free_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            // I-type ALU and LUI have no second register source
            w_elig[i] = r_valid[i] && w_rdy1_eff[i] &&
                        (w_rdy2_eff[i] || r_opcode[i] == 7'b0010011 || r_opcode[i] == 7'b0110111);
            if (w_elig[i] && (!w_found || f_dist(r_rob[i], rob_head) < w_best_age)) begin
                w_found    = 1'b1;
                w_win      = IW'(i);
                w_best_age = f_dist(r_rob[i], rob_head);
            end
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!r_valid[i]) w_free_idx = IW'(i);
    end

    assign rs_full       = &r_valid;
    assign w_disp        = disp_valid && !rs_full && !mispredict;
    assign issued        = fu_alu_ready && w_found && !mispredict;
    assign iss_opcode    = issued ? r_opcode[w_win] : '0;
    assign iss_func3     = issued ? r_func3[w_win]  : '0;
    assign iss_func7     = issued ? r_func7[w_win]  : '0;
    assign iss_imm       = issued ? r_imm[w_win]    : '0;
    assign iss_ps1       = issued ? r_ps1[w_win]    : '0;
    assign iss_ps2       = issued ? r_ps2[w_win]    : '0;
    assign iss_pd        = issued ? r_pd[w_win]     : '0;
    assign iss_rob_index = issued ? r_rob[w_win]    : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_opcode[i] <= '0;
                r_func3[i]  <= '0;
                r_func7[i]  <= '0;
                r_imm[i]    <= '0;
                r_ps1[i]    <= '0;
                r_ps2[i]    <= '0;
                r_pd[i]     <= '0;
                r_rob[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_valid[i]) begin
                    r_rdy1[i] <= r_rdy1[i] | w_wake1[i];
                    r_rdy2[i] <= r_rdy2[i] | w_wake2[i];
                    if ((mispredict && w_flush[i]) || (issued && w_win == IW'(i))) r_valid[i] <= 1'b0;
                end else if (w_disp && w_free_idx == IW'(i)) begin
                    r_valid[i]  <= 1'b1;
                    r_opcode[i] <= disp_opcode;
                    r_func3[i]  <= disp_func3;
                    r_func7[i]  <= disp_func7;
                    r_imm[i]    <= disp_imm;
                    r_ps1[i]    <= disp_ps1;
                    r_ps2[i]    <= disp_ps2;
                    r_pd[i]     <= disp_pd;
                    r_rob[i]    <= disp_rob_index;
                    r_rdy1[i]   <= disp_ps1_rdy || disp_ps1 == 7'd0 || (cdb_valid && cdb_tag == disp_ps1);
                    r_rdy2[i]   <= disp_ps2_rdy || disp_ps2 == 7'd0 || (cdb_valid && cdb_tag == disp_ps2);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_sched.sv
// tb_alu_issue_sched: directed scenarios plus random traffic checked every cycle against a queue model.
// The model tracks ops by unbounded ROB sequence numbers, so age and flush are plain integer comparisons.
module tb_alu_issue_sched;
    localparam int RS = 8;
    localparam int RD = 16;
`ifdef ALU_RS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0, reset;
    logic        disp_valid, disp_ps1_rdy, disp_ps2_rdy, cdb_valid, mispredict, fu_alu_ready;
    logic [6:0]  disp_opcode, disp_func7, disp_ps1, disp_ps2, disp_pd, cdb_tag;
    logic [2:0]  disp_func3;
    logic [31:0] disp_imm;
    logic [4:0]  disp_rob_index, rob_head, rob_tail, mispredict_tag;
    logic        rs_full, issued;
    logic [6:0]  iss_opcode, iss_func7, iss_ps1, iss_ps2, iss_pd;
    logic [2:0]  iss_func3;
    logic [31:0] iss_imm;
    logic [4:0]  iss_rob_index;

    int d_ctr, head_ctr, tail_ctr, m_ctr;
    int tests = 0, fails = 0;

    typedef struct {
        int         ctr;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] imm;
        logic [6:0] ps1, ps2, pd;
        bit         r1, r2;
    } ent_t;
    ent_t q[$];

    assign disp_rob_index = 5'(d_ctr % RD);
    assign rob_head       = 5'(head_ctr % RD);
    assign rob_tail       = 5'(tail_ctr % RD);
    assign mispredict_tag = 5'(m_ctr % RD);

    always #5 clk = ~clk;

    alu_issue_sched #(.RS_DEPTH(RS), .ROB_DEPTH(RD)) dut (
        .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_opcode(disp_opcode),
        .disp_func3(disp_func3), .disp_func7(disp_func7), .disp_imm(disp_imm),
        .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_pd(disp_pd),
        .disp_rob_index(disp_rob_index), .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
        .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .rob_head(rob_head),
        .rob_tail(rob_tail), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .fu_alu_ready(fu_alu_ready), .issued(issued), .iss_opcode(iss_opcode),
        .iss_func3(iss_func3), .iss_func7(iss_func7), .iss_imm(iss_imm), .iss_ps1(iss_ps1),
        .iss_ps2(iss_ps2), .iss_pd(iss_pd), .iss_rob_index(iss_rob_index)
    );

    task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // oldest eligible op by sequence number; -1 when none
    function automatic int pick();
        int best = -1;
        for (int i = 0; i < q.size(); i++) begin
            bit r1 = q[i].r1 || (BYP && cdb_valid && cdb_tag == q[i].ps1);
            bit r2 = q[i].r2 || (BYP && cdb_valid && cdb_tag == q[i].ps2);
            bit ok = r1 && (r2 || q[i].op == 7'b0010011 || q[i].op == 7'b0110111);
            if (ok && (best < 0 || q[i].ctr < q[best].ctr)) best = i;
        end
        return best;
    endfunction

    task automatic compare();
        int w = pick();
        bit ei = fu_alu_ready && (w >= 0) && !mispredict;
        logic [79:0] exp = '0;
        if (ei) exp = 80'({q[w].op, q[w].f3, q[w].f7, q[w].imm, q[w].ps1, q[w].ps2, q[w].pd, 5'(q[w].ctr % RD)});
        chk("rs_full", 80'(rs_full), 80'(q.size() == RS));
        chk("issued", 80'(issued), 80'(ei));
        chk("iss_fields", 80'({iss_opcode, iss_func3, iss_func7, iss_imm, iss_ps1, iss_ps2, iss_pd, iss_rob_index}), exp);
    endtask

    task automatic update();
        int w = pick();
        bit ei = fu_alu_ready && (w >= 0) && !mispredict;
        bit full = (q.size() == RS);
        for (int i = 0; i < q.size(); i++) begin
            if (cdb_valid && cdb_tag == q[i].ps1) q[i].r1 = 1'b1;
            if (cdb_valid && cdb_tag == q[i].ps2) q[i].r2 = 1'b1;
        end
        if (mispredict) begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].ctr > m_ctr && q[i].ctr < tail_ctr) q.delete(i);
            tail_ctr = m_ctr + 1;
        end else begin
            if (ei) q.delete(w);
            if (disp_valid && !full) begin
                ent_t e;
                e.ctr = d_ctr; e.op = disp_opcode; e.f3 = disp_func3; e.f7 = disp_func7;
                e.imm = disp_imm; e.ps1 = disp_ps1; e.ps2 = disp_ps2; e.pd = disp_pd;
                e.r1 = disp_ps1_rdy || disp_ps1 == 7'd0 || (cdb_valid && cdb_tag == disp_ps1);
                e.r2 = disp_ps2_rdy || disp_ps2 == 7'd0 || (cdb_valid && cdb_tag == disp_ps2);
                q.push_back(e);
                if (d_ctr + 1 > tail_ctr) tail_ctr = d_ctr + 1;
            end
        end
        head_ctr = tail_ctr;
        foreach (q[i]) if (q[i].ctr < head_ctr) head_ctr = q[i].ctr;
    endtask

    task automatic tick();
        #1 compare();
        @(posedge clk);
        #1 update();
        @(negedge clk);
    endtask

    task automatic idle(input bit fu);
        disp_valid = 1'b0; cdb_valid = 1'b0; mispredict = 1'b0; fu_alu_ready = fu;
    endtask

    task automatic set_disp(input logic [6:0] op, input int ctr, input logic [6:0] p1, input bit r1,
                            input logic [6:0] p2, input bit r2);
        disp_valid = 1'b1; disp_opcode = op; d_ctr = ctr;
        disp_func3 = 3'($urandom); disp_func7 = 7'($urandom); disp_imm = $urandom;
        disp_pd = 7'($urandom); disp_ps1 = p1; disp_ps1_rdy = r1; disp_ps2 = p2; disp_ps2_rdy = r2;
    endtask

    task automatic set_tail(input int n);
        tail_ctr = n;
        if (q.size() == 0) head_ctr = n;
    endtask

    initial begin
        logic [6:0] ops [3];
        int o23 [3];
        ops = '{7'b0010011, 7'b0110111, 7'b0110011};
        o23 = '{14, 15, 1};
        reset = 1'b1; idle(1'b0); cdb_tag = '0; d_ctr = 0; head_ctr = 0; tail_ctr = 0; m_ctr = 0;
        set_disp(7'd0, 0, 7'd0, 1'b0, 7'd0, 1'b0); disp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1 chk("reset_full", 80'(rs_full), 80'(0));
        chk("reset_issued", 80'(issued), 80'(0));
        tick();

        // single addi issues the cycle after dispatch
        set_tail(3); idle(1'b1);
        set_disp(7'b0010011, 3, 7'd5, 1'b1, 7'd6, 1'b0); tick();
        idle(1'b1);
        #1 chk("r21_issued", 80'(issued), 80'(1));
        chk("r21_rob", 80'(iss_rob_index), 80'(3));
        tick();
        #1 chk("r21_freed", 80'(issued), 80'(0));
        tick();

        // fill, wake all on P20, drain oldest first
        for (int k = 0; k < 8; k++) begin set_disp(7'b0110011, 4 + k, 7'd20, 1'b0, 7'd0, 1'b0); tick(); end
        idle(1'b1);
        #1 chk("r22_full", 80'(rs_full), 80'(1));
        cdb_valid = 1'b1; cdb_tag = 7'd20; tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifndef ALU_RS_BYPASS_EN
            #1 chk("r22_order", 80'(iss_rob_index), 80'(4 + k));
`endif
            if (k == 1) chk("r22_notfull", 80'(rs_full), 80'(0));
            tick();
        end
        tick();

        // age relative to rob_head across the tag wrap
        idle(1'b0);
        set_disp(7'b0110011, 15, 7'd21, 1'b0, 7'd0, 1'b0); tick();
        set_disp(7'b0110011, 17, 7'd21, 1'b0, 7'd0, 1'b0); tick();
        set_disp(7'b0110011, 14, 7'd21, 1'b0, 7'd0, 1'b0); tick();
        idle(1'b1); cdb_valid = 1'b1; cdb_tag = 7'd21; tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
`ifndef ALU_RS_BYPASS_EN
            #1 chk("r23_order", 80'(iss_rob_index), 80'(o23[k]));
`endif
            tick();
        end
        tick();

        // flush younger than rob 4 with tail 8; wakeup still reaches survivors
        idle(1'b0);
        for (int k = 0; k < 6; k++) begin set_disp(7'b0110011, 18 + k, 7'd22, 1'b0, 7'd0, 1'b0); tick(); end
        idle(1'b1); mispredict = 1'b1; m_ctr = 20; cdb_valid = 1'b1; cdb_tag = 7'd22;
        set_disp(7'b0010011, 24, 7'd0, 1'b1, 7'd0, 1'b1);
        #1 chk("r24_noissue", 80'(issued), 80'(0));
        tick();
        idle(1'b1);
        for (int k = 0; k < 3; k++) begin
            #1 chk("r24_kept", 80'(iss_rob_index), 80'(2 + k));
            tick();
        end
        #1 chk("r24_flushed", 80'(issued), 80'(0));
        tick();

        // flush window starting after tag 15 wraps to 0
        idle(1'b0); set_tail(30);
        for (int k = 0; k < 4; k++) begin set_disp(7'b0110011, 30 + k, 7'd23, 1'b0, 7'd0, 1'b0); tick(); end
        idle(1'b0); mispredict = 1'b1; m_ctr = 31; tick();
        idle(1'b1); cdb_valid = 1'b1; cdb_tag = 7'd23; tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
`ifndef ALU_RS_BYPASS_EN
            #1 chk("r24w_kept", 80'(iss_rob_index), 80'(14 + k));
`endif
            tick();
        end
        #1 chk("r24w_flushed", 80'(issued), 80'(0));
        tick();

        // same-cycle CDB capture at dispatch, and bypass behaviour for a held entry
        idle(1'b0);
        set_disp(7'b0110011, 32, 7'd9, 1'b0, 7'd0, 1'b0); tick();
        idle(1'b1); cdb_valid = 1'b1; cdb_tag = 7'd9;
        set_disp(7'b0110011, 33, 7'd0, 1'b1, 7'd9, 1'b0);
        #1 chk("r25_same", 80'(issued), 80'(BYP));
        tick();
        idle(1'b1);
        #1 chk("r25_next", 80'(iss_rob_index), 80'(BYP ? 1 : 0));
        tick(); tick(); tick();

        // async reset discards held ops immediately
        idle(1'b0);
        for (int k = 0; k < 5; k++) begin set_disp(7'b0110011, 34 + k, 7'd30, 1'b0, 7'd0, 1'b0); tick(); end
        idle(1'b1); cdb_valid = 1'b1; cdb_tag = 7'd30; reset = 1'b1;
        #1 chk("r26_full", 80'(rs_full), 80'(0));
        chk("r26_issued", 80'(issued), 80'(0));
        q.delete();
        @(posedge clk); @(negedge clk);
        reset = 1'b0; set_tail(tail_ctr);
        tick(); idle(1'b1); tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            idle($urandom % 4 != 0);
            cdb_valid = 1'($urandom % 2); cdb_tag = 7'($urandom % 8);
            if (tail_ctr > head_ctr && $urandom % 20 == 0) begin
                mispredict = 1'b1;
                m_ctr = head_ctr + int'($urandom % 32'(tail_ctr - head_ctr));
            end
            if (q.size() < RS && tail_ctr - head_ctr < 15 && $urandom % 10 < 7)
                set_disp(ops[$urandom % 3], tail_ctr, 7'($urandom % 8), $urandom % 4 == 0,
                         7'($urandom % 8), $urandom % 4 == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
